// File: rtl/conv_layer_sched.sv
// -----------------------------------------------------------------------------
// conv_layer_sched
//
// Layer-level sequencer between the host CSR side and instgen. The host queues
// packed conv-layer descriptors; after start, each descriptor is popped, handed
// to instgen over a valid/ready handshake, and the next one is issued only
// after instgen reports compute_done. A descriptor with its chain bit set takes
// its input buffer and geometry from the previous layer's output, so a
// multi-layer network runs without host involvement between layers.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   desc_in           packed descriptor to enqueue
//   push_valid        enqueue request; push_ready = FIFO not full
//   start             one-cycle pulse, begins a run when idle
//   abort             one-cycle pulse, flushes the queue and ends the run
//   cmd_desc          descriptor presented to instgen (held between fetches)
//   csrcmd_valid      command valid to instgen; instgen_ready accepts it
//   compute_done      instgen layer-complete pulse
//   busy              sequencer not idle
//   sched_done        one-cycle pulse at the end of a run
//   aborted           sticky, last run was terminated by abort
//   overflow          sticky, a push arrived while the FIFO was full
//   layers_done       layers completed in the current/last run (saturating)
//   fifo_count        FIFO occupancy
//
// Descriptor layout
//   [31:0] feature_baseaddr  [63:32] kernel_baseaddr  [95:64] output_baseaddr
//   [127:96] feature_width   [159:128] feature_height
//   [191:160] feature_chin   [223:192] feature_chout
//   [255:224] output_width   [287:256] output_height
//   [295:288] kernel_sizeh   [303:296] kernel_sizew   [311:304] stride
//   [312] has_bias           [313] has_relu           [314] chain
//
// State table
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for start; queue may be filled by the host
//   S_FETCH  | pop queue head into cmd_desc, applying chain substitution
//   S_ISSUE  | csrcmd_valid high until instgen_ready completes handshake
//   S_RUN    | instgen computing; wait for compute_done
//   S_FINISH | sched_done pulse, then back to idle
// -----------------------------------------------------------------------------
module conv_layer_sched #(
    parameter int DEPTH  = 8,
    parameter int DESC_W = 315
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DESC_W-1:0]      desc_in,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic                   start,
    input  logic                   abort,
    output logic [DESC_W-1:0]      cmd_desc,
    output logic                   csrcmd_valid,
    input  logic                   instgen_ready,
    input  logic                   compute_done,
    output logic                   busy,
    output logic                   sched_done,
    output logic                   aborted,
    output logic                   overflow,
    output logic [15:0]            layers_done,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Field positions inside the packed descriptor.
    localparam int F_FBASE_LO  = 0;
    localparam int F_OBASE_LO  = 64;
    localparam int F_FWIDTH_LO = 96;
    localparam int F_FHEIGH_LO = 128;
    localparam int F_FCHIN_LO  = 160;
    localparam int F_FCHOUT_LO = 192;
    localparam int F_OWIDTH_LO = 224;
    localparam int F_OHEIGH_LO = 256;
    localparam int F_CHAIN     = 314;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RUN,
        S_FINISH
    } state_t;

    state_t state;

    // Descriptor FIFO
    logic [DESC_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push_req;
    logic              pop_req;

    // Previous-layer output geometry, used by chained descriptors
    logic [31:0]       prev_obase;
    logic [31:0]       prev_owidth;
    logic [31:0]       prev_oheight;
    logic [31:0]       prev_chout;
    logic              prev_valid;

    // Abort seen during RUN; the layer in flight must still drain
    logic              abort_pend;

    logic [DESC_W-1:0] head_desc;
    logic [DESC_W-1:0] fetch_desc;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign fifo_count = count;
    assign busy       = (state != S_IDLE);

    // Abort flushes the queue, so neither a push nor the FETCH pop may land
    // in the same cycle.
    assign push_req = push_valid && !full && !abort;
    assign pop_req  = (state == S_FETCH) && !abort;

    assign head_desc = mem[rd_ptr];

    always_comb begin
        fetch_desc = head_desc;
        if (head_desc[F_CHAIN] && prev_valid) begin
            fetch_desc[F_FBASE_LO  +: 32] = prev_obase;
            fetch_desc[F_FWIDTH_LO +: 32] = prev_owidth;
            fetch_desc[F_FHEIGH_LO +: 32] = prev_oheight;
            fetch_desc[F_FCHIN_LO  +: 32] = prev_chout;
        end
    end

    // Storage array needs no reset: occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push_req) begin
            mem[wr_ptr] <= desc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            cmd_desc     <= '0;
            csrcmd_valid <= 1'b0;
            sched_done   <= 1'b0;
            aborted      <= 1'b0;
            overflow     <= 1'b0;
            layers_done  <= '0;
            prev_obase   <= '0;
            prev_owidth  <= '0;
            prev_oheight <= '0;
            prev_chout   <= '0;
            prev_valid   <= 1'b0;
            abort_pend   <= 1'b0;
        end else begin
            sched_done <= 1'b0;

            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_req) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_req) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push_req, pop_req})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        layers_done <= '0;
                        aborted     <= 1'b0;
                        overflow    <= 1'b0;
                        prev_valid  <= 1'b0;
                        abort_pend  <= 1'b0;
                        if (!empty && !abort) begin
                            state <= S_FETCH;
                        end else begin
                            state      <= S_FINISH;
                            sched_done <= 1'b1;
                        end
                    end
                end

                S_FETCH: begin
                    if (abort) begin
                        state      <= S_FINISH;
                        sched_done <= 1'b1;
                    end else begin
                        cmd_desc     <= fetch_desc;
                        csrcmd_valid <= 1'b1;
                        state        <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    // Abort withdraws the command even if ready is also high.
                    if (abort) begin
                        csrcmd_valid <= 1'b0;
                        state        <= S_FINISH;
                        sched_done   <= 1'b1;
                    end else if (instgen_ready) begin
                        csrcmd_valid <= 1'b0;
                        state        <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (compute_done) begin
                        if (layers_done != 16'hFFFF) begin
                            layers_done <= layers_done + 16'd1;
                        end
                        prev_obase   <= cmd_desc[F_OBASE_LO  +: 32];
                        prev_owidth  <= cmd_desc[F_OWIDTH_LO +: 32];
                        prev_oheight <= cmd_desc[F_OHEIGH_LO +: 32];
                        prev_chout   <= cmd_desc[F_FCHOUT_LO +: 32];
                        prev_valid   <= 1'b1;
                        if (abort || abort_pend || empty) begin
                            state      <= S_FINISH;
                            sched_done <= 1'b1;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end

                S_FINISH: begin
                    abort_pend <= 1'b0;
                    state      <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Placed after the start handling so a concurrent drop still
            // records the overflow.
            if (push_valid && full) begin
                overflow <= 1'b1;
            end

            if (abort && (state != S_IDLE)) begin
                aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
module tb_conv_layer_sched;

    localparam int DEPTH  = 8;
    localparam int DESC_W = 315;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [DESC_W-1:0] desc_in;
    logic              push_valid;
    logic              push_ready;
    logic              start;
    logic              abort;
    logic [DESC_W-1:0] cmd_desc;
    logic              csrcmd_valid;
    logic              instgen_ready;
    logic              compute_done;
    logic              busy;
    logic              sched_done;
    logic              aborted;
    logic              overflow;
    logic [15:0]       layers_done;
    logic [CW-1:0]     fifo_count;

    always #5 clk = ~clk;

    conv_layer_sched #(.DEPTH(DEPTH), .DESC_W(DESC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .desc_in       (desc_in),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .start         (start),
        .abort         (abort),
        .cmd_desc      (cmd_desc),
        .csrcmd_valid  (csrcmd_valid),
        .instgen_ready (instgen_ready),
        .compute_done  (compute_done),
        .busy          (busy),
        .sched_done    (sched_done),
        .aborted       (aborted),
        .overflow      (overflow),
        .layers_done   (layers_done),
        .fifo_count    (fifo_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queued descriptors and the last layer handed to instgen.
    logic [DESC_W-1:0] m_q[$];
    logic [DESC_W-1:0] m_prev;
    bit                m_prev_valid;
    logic [DESC_W-1:0] last_cmd;
    int                r_hs;
    int                r_done;

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DESC_W-1:0] rand_desc(input bit chain);
        logic [319:0]      w;
        logic [DESC_W-1:0] d;
        for (int i = 0; i < 10; i++) w[i*32 +: 32] = $urandom();
        d = w[DESC_W-1:0];
        d[314] = chain;
        return d;
    endfunction

    // What instgen should receive for the next queued layer of a run.
    function automatic logic [DESC_W-1:0] model_issue(input logic [DESC_W-1:0] d);
        logic [DESC_W-1:0] r;
        r = d;
        if (d[314] && m_prev_valid) begin
            r[31:0]    = m_prev[95:64];
            r[127:96]  = m_prev[255:224];
            r[159:128] = m_prev[287:256];
            r[191:160] = m_prev[223:192];
        end
        m_prev       = r;
        m_prev_valid = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        desc_in = '0; push_valid = 0; start = 0; abort = 0;
        instgen_ready = 0; compute_done = 0;
        tick();
        tick();
        rst = 1'b0;
        m_q.delete();
        m_prev_valid = 0;
    endtask

    task automatic push_one(input logic [DESC_W-1:0] d);
        chk("push_ready", push_ready, (m_q.size() < DEPTH));
        desc_in = d;
        push_valid = 1'b1;
        tick();
        push_valid = 1'b0;
        if (m_q.size() < DEPTH) m_q.push_back(d);
    endtask

    task automatic do_start();
        bit nonempty;
        nonempty = (m_q.size() > 0);
        start = 1'b1;
        m_prev_valid = 0;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("overflow_cleared", overflow, 0);
        chk("aborted_cleared", aborted, 0);
        chk("layers_cleared", layers_done, 0);
        if (nonempty) begin
            chk("no_valid_in_fetch", csrcmd_valid, 0);
            tick();
            chk("valid_at_n2", csrcmd_valid, 1);
        end
    endtask

    // Behaves as instgen for one run and follows the run to its sched_done.
    task automatic run_sched(input int max_cyc, input int lat_min, input int lat_max,
                             input int rdy_pct, input int hold, input int abort_layer);
        int cd;
        int hold_left;
        bit in_issue;
        bit finished;
        bit abort_next;
        logic [DESC_W-1:0] held;
        logic [DESC_W-1:0] d;
        logic [DESC_W-1:0] e;
        cd = -1; hold_left = 0; in_issue = 0; finished = 0; abort_next = 0; held = '0;
        r_hs = 0; r_done = 0;
        for (int c = 0; c < max_cyc; c++) begin
            instgen_ready = 0; compute_done = 0; abort = 0;
            if (sched_done) begin
                finished = 1;
                break;
            end
            if (abort_next) begin
                abort = 1'b1;
                abort_next = 0;
                m_q.delete();
            end
            if (cd == 0) begin
                compute_done = 1'b1;
                cd = -1;
                r_done++;
            end else if (cd > 0) begin
                cd--;
            end
            if (csrcmd_valid) begin
                if (!in_issue) begin
                    in_issue = 1;
                    hold_left = hold;
                    held = cmd_desc;
                end else begin
                    chk("issue_desc_stable", cmd_desc, held);
                end
                if (hold_left > 0) hold_left--;
                else instgen_ready = ($urandom_range(99) < rdy_pct);
                if (instgen_ready) begin
                    in_issue = 0;
                    if (m_q.size() == 0) begin
                        chk("unexpected_cmd", 1, 0);
                    end else begin
                        d = m_q.pop_front();
                        e = model_issue(d);
                        chk("cmd_desc", cmd_desc, e);
                    end
                    last_cmd = cmd_desc;
                    if (r_hs == abort_layer) abort_next = 1;
                    r_hs++;
                    cd = $urandom_range(lat_max, lat_min);
                end
            end else if (in_issue) begin
                chk("valid_dropped", 0, 1);
                in_issue = 0;
            end
            tick();
            if (abort) begin
                chk("flush_count", fifo_count, 0);
                chk("busy_during_abort", busy, 1);
            end
        end
        instgen_ready = 0; compute_done = 0; abort = 0;
        if (!finished) begin
            chk("sched_done_timeout", 0, 1);
        end else begin
            tick();
            chk("sched_done_one_cycle", sched_done, 0);
            chk("idle_after_finish", busy, 0);
        end
        chk("layers_done", layers_done, r_done);
        chk("fifo_count_end", fifo_count, m_q.size());
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [DESC_W-1:0] a;
        logic [DESC_W-1:0] b;
        int seen;
        int n;

        do_reset();
        chk("rst_push_ready", push_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", csrcmd_valid, 0);
        chk("rst_sched_done", sched_done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_layers", layers_done, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_cmd_desc", cmd_desc, 0);

        // Abort while idle only flushes.
        push_one(rand_desc(0));
        push_one(rand_desc(0));
        chk("count_two", fifo_count, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_q.delete();
        chk("idle_abort_count", fifo_count, 0);
        chk("idle_abort_sticky", aborted, 0);
        chk("idle_abort_busy", busy, 0);

        // Three plain layers, fixed 20-cycle compute.
        for (int i = 0; i < 3; i++) push_one(rand_desc(0));
        chk("count_three", fifo_count, 3);
        do_start();
        run_sched(2000, 20, 20, 100, 0, -1);
        chk("three_handshakes", r_hs, 3);

        // compute_done while idle is ignored.
        compute_done = 1'b1;
        tick();
        compute_done = 1'b0;
        chk("idle_done_ignored", layers_done, 3);
        chk("idle_done_busy", busy, 0);

        // Chaining: B picks up A's output buffer and geometry.
        a = rand_desc(0);
        a[95:64]   = 32'h1000;
        a[255:224] = 32'd30;
        a[287:256] = 32'd30;
        a[223:192] = 32'd16;
        b = rand_desc(1);
        b[31:0] = 32'h9999;
        push_one(a);
        push_one(b);
        do_start();
        run_sched(2000, 5, 15, 70, 0, -1);
        chk("chain_fbase", last_cmd[31:0], 32'h1000);
        chk("chain_fwidth", last_cmd[127:96], 32'd30);
        chk("chain_fheight", last_cmd[159:128], 32'd30);
        chk("chain_chin", last_cmd[191:160], 32'd16);

        // instgen_ready held low for 5 cycles in ISSUE.
        push_one(rand_desc($urandom_range(1, 0)));
        do_start();
        run_sched(2000, 4, 8, 100, 5, -1);
        chk("hold_handshakes", r_hs, 1);

        // Abort in RUN of layer 1 of 4.
        for (int i = 0; i < 4; i++) push_one(rand_desc(0));
        do_start();
        run_sched(2000, 10, 10, 100, 0, 0);
        chk("abort_run_hs", r_hs, 1);
        chk("abort_run_sticky", aborted, 1);

        // Overflow: DEPTH+1 pushes with no pops.
        for (int i = 0; i < DEPTH + 1; i++) push_one(rand_desc($urandom_range(1, 0)));
        chk("full_push_ready", push_ready, 0);
        chk("full_count", fifo_count, DEPTH);
        chk("full_overflow", overflow, 1);
        do_start();
        run_sched(4000, 1, 10, 60, 1, -1);
        chk("full_run_hs", r_hs, DEPTH);

        // Empty start.
        do_start();
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (sched_done) seen++;
            chk("empty_no_valid", csrcmd_valid, 0);
            tick();
        end
        chk("empty_sched_once", seen, 1);
        chk("empty_layers", layers_done, 0);
        chk("empty_idle", busy, 0);

        // Abort while the command is still being offered.
        push_one(rand_desc(0));
        push_one(rand_desc(0));
        do_start();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        m_q.delete();
        chk("issue_abort_valid", csrcmd_valid, 0);
        chk("issue_abort_sched", sched_done, 1);
        chk("issue_abort_count", fifo_count, 0);
        chk("issue_abort_sticky", aborted, 1);
        tick();
        chk("issue_abort_idle", busy, 0);
        chk("issue_abort_layers", layers_done, 0);

        // Randomized runs.
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(DEPTH, 1);
            for (int i = 0; i < n; i++) push_one(rand_desc($urandom_range(1, 0)));
            do_start();
            run_sched(4000, 1, 12, 60, $urandom_range(2, 0), -1);
            chk("rand_hs", r_hs, n);
        end

        // Reset in the middle of a run.
        for (int i = 0; i < 3; i++) push_one(rand_desc(0));
        do_start();
        tick();
        do_reset();
        chk("midrst_valid", csrcmd_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", fifo_count, 0);
        chk("midrst_layers", layers_done, 0);
        chk("midrst_push_ready", push_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
